// File: rtl/nibble_serial_bla_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: D = A - B - Bin, one 4-bit nibble per clock.
// Each nibble is resolved by a 4-bit borrow-lookahead stage; a start/busy/done
// handshake sequences the operation. Optional macro SUB_OVERFLOW_EN adds a
// registered signed-overflow output (ovf).
module nibble_serial_bla_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic               br_q, br_n;
  logic [WIDTH-1:0]   d_n;
  logic               bout_n;
  logic               busy_n;
  logic               done_n;
  logic               accept;
`ifdef SUB_OVERFLOW_EN
  logic               sa_q, sa_n;
  logic               sb_q, sb_n;
  logic               ovf_n;
`endif

  // Current nibble operands: operand registers shift right, so the live nibble is always [3:0].
  logic [3:0] nib_a, nib_b, g, p, nib_d;
  logic [4:0] br;
  logic [IDX_W+1:0] slice_sh;

  assign nib_a    = a_q[3:0];
  assign nib_b    = b_q[3:0];
  assign slice_sh = {idx_q, 2'b00};

  // Borrow-lookahead nibble stage: generate/propagate, fully expanded borrow terms.
  always_comb begin
    g     = ~nib_a & nib_b;
    p     = ~(nib_a ^ nib_b);
    br[0] = br_q;
    br[1] = g[0] | (p[0] & br_q);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_q);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br_q);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & br_q);
    nib_d = nib_a ^ nib_b ^ br[3:0];
  end

  // Next-state and datapath update: sequence nibbles, capture operands on accepted start.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    a_n     = a_q;
    b_n     = b_q;
    br_n    = br_q;
    d_n     = d;
    bout_n  = bout;
    accept  = 1'b0;
`ifdef SUB_OVERFLOW_EN
    sa_n    = sa_q;
    sb_n    = sb_q;
    ovf_n   = ovf;
`endif

    case (state_q)
      S_IDLE: begin
        accept = start;
      end
      S_RUN: begin
        d_n   = (d & ~(WIDTH'(4'hF) << slice_sh)) | (WIDTH'(nib_d) << slice_sh);
        a_n   = a_q >> 4;
        b_n   = b_q >> 4;
        br_n  = br[4];
        idx_n = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_n = S_DONE;
          idx_n   = '0;
          bout_n  = br[4];
`ifdef SUB_OVERFLOW_EN
          ovf_n   = (sa_q != sb_q) && (nib_d[3] != sa_q);
`endif
        end
      end
      S_DONE: begin
        accept  = start;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (accept) begin
      state_n = S_RUN;
      idx_n   = '0;
      a_n     = a;
      b_n     = b;
      br_n    = bin;
`ifdef SUB_OVERFLOW_EN
      sa_n    = a[WIDTH-1];
      sb_n    = b[WIDTH-1];
`endif
    end

    busy_n = (state_n == S_RUN);
    done_n = (state_n == S_DONE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      d       <= '0;
      bout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      a_q     <= a_n;
      b_q     <= b_n;
      br_q    <= br_n;
      d       <= d_n;
      bout    <= bout_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SUB_OVERFLOW_EN
      sa_q    <= sa_n;
      sb_q    <= sb_n;
      ovf     <= ovf_n;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_serial_bla_subtractor.sv
// Testbench for nibble_serial_bla_subtractor (WIDTH=16): table-driven vectors
// plus hand-written sequences for back-to-back start and mid-run reset.
module tb_nibble_serial_bla_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        bout;
`ifdef SUB_OVERFLOW_EN
  logic        ovf;
`endif

  int n_vec;
  int n_fail;

  nibble_serial_bla_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for done after an accepted start; returns the number of edges taken.
  task automatic wait_done(input string name, output int cyc);
    int overlap;
    bit got;
    cyc = 0;
    overlap = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && done) overlap++;
      if (done) got = 1'b1;
    end
    check({name, " latency"}, 32'(cyc), 32'd4);
    check({name, " busy&done overlap"}, 32'(overlap), 32'd0);
  endtask

  // Issues one operation (caller sits between edges), scrambles inputs during RUN, checks result.
  task automatic run_op(input vec_t v, input string name);
    int cyc;
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    bin   = v.bin;
    @(posedge clk);
    #1;
    check({name, " busy after accept"}, 32'(busy), 32'd1);
    start = 1'b0;
    a     = ~v.a;
    b     = ~v.b;
    bin   = ~v.bin;
    wait_done(name, cyc);
    check({name, " d"}, 32'(d), 32'(v.d));
    check({name, " bout"}, 32'(bout), 32'(v.bout));
`ifdef SUB_OVERFLOW_EN
    check({name, " ovf"}, 32'(ovf), 32'(v.ovf));
`endif
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    int seen_done;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[9] = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1, 1'b0};

    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset d", 32'(d), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors; even entries get idle gaps, odd entries run back-to-back from DONE.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        @(posedge clk);
        #1;
        check("vec0 done single-cycle", 32'(done), 32'd0);
        check("vec0 d hold", 32'(d), 32'h1000);
      end else if (i % 2 == 0) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;

    // start held high with changing operands: first result from captured values, then a
    // back-to-back second run accepted in the DONE cycle.
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h0234;
    bin   = 1'b0;
    @(posedge clk);
    #1;
    a = 16'h0010;
    b = 16'h0001;
    wait_done("hold1", cyc);
    check("hold1 d", 32'(d), 32'h1000);
    check("hold1 bout", 32'(bout), 32'd0);
    @(posedge clk);
    #1;
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    start = 1'b0;
    a     = 16'hDEAD;
    b     = 16'hBEEF;
    wait_done("b2b", cyc);
    check("b2b d", 32'(d), 32'h000F);
    check("b2b bout", 32'(bout), 32'd0);

    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset at nibble index 2: outputs clear at once, no done follows.
    start = 1'b1;
    a     = 16'hABCD;
    b     = 16'h1234;
    bin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst d", 32'(d), 32'd0);
    check("async rst bout", 32'(bout), 32'd0);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    check("no done after reset", 32'(seen_done), 32'd0);
    run_op(vecs[8], "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
